// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: opcode constants, FSM state encoding and NOP word shared by fetch and control
package fetch_unit_pkg;
  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_IADD = 4'b0110;
  localparam logic [3:0] OP_LDM  = 4'b1100;
  localparam logic [3:0] OP_LDD  = 4'b1101;
  localparam logic [3:0] OP_STD  = 4'b1110;
  localparam logic [15:0] NOP_WORD = 16'h0000;
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, INT_VEC = 2'd2} state_e;
endpackage

// File: rtl/fetch_unit_two_word_detect.sv
// two_word_detect: opcode -> is_two_word (1 when the next memory word is an immediate)
module two_word_detect
  import fetch_unit_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_two_word
);
  assign is_two_word = opcode inside {OP_IADD, OP_LDM, OP_LDD, OP_STD};
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC/FSM/IF-ID register; in clk,reset(n),imem_data,stall,branch_*,int_req; out imem_addr,if_id_*,int_ack,int_ret_pc
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_W = 16,
  parameter int INSTR_W = 16,
  parameter logic [PC_W-1:0] RESET_VEC_ADDR = '0,
  parameter logic [PC_W-1:0] INT_VEC_ADDR = PC_W'(1)
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               int_req,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_imm,
  output logic [PC_W-1:0]    if_id_pc1,
  output logic               int_ack,
  output logic [PC_W-1:0]    int_ret_pc
);
  state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc1_q, pc1_d, ret_pc_q, ret_pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic imm_q, imm_d, imm_expect_q, imm_expect_d;
  logic int_pending_q, int_pending_d, int_ack_q, int_ack_d;
  logic is_two_word, take_int;
  logic [PC_W-1:0] pc_inc;
  two_word_detect u_detect (
    .opcode      (imem_data[INSTR_W-1 -: 4]),
    .is_two_word (is_two_word)
  );
  // never split an opcode from its immediate word
  assign take_int = int_pending_q && !imm_expect_q;
  assign pc_inc = pc_q + PC_W'(1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= BOOT;
      pc_q          <= '0;
      instr_q       <= '0;
      imm_q         <= 1'b0;
      pc1_q         <= '0;
      ret_pc_q      <= '0;
      imm_expect_q  <= 1'b0;
      int_pending_q <= 1'b0;
      int_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      imm_q         <= imm_d;
      pc1_q         <= pc1_d;
      ret_pc_q      <= ret_pc_d;
      imm_expect_q  <= imm_expect_d;
      int_pending_q <= int_pending_d;
      int_ack_q     <= int_ack_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = (!branch_taken && !stall && take_int) ? INT_VEC : RUN;
      INT_VEC: state_d = stall ? INT_VEC : RUN;
      default: state_d = BOOT;
    endcase
  end
  always_comb begin
    imem_addr     = state_q == BOOT ? RESET_VEC_ADDR : state_q == INT_VEC ? INT_VEC_ADDR : pc_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    imm_d         = imm_q;
    pc1_d         = pc1_q;
    ret_pc_d      = ret_pc_q;
    imm_expect_d  = imm_expect_q;
    int_pending_d = int_pending_q | int_req;
    int_ack_d     = 1'b0;
    case (state_q)
      BOOT: begin
        pc_d         = PC_W'(imem_data);
        instr_d      = INSTR_W'(NOP_WORD);
        imm_d        = 1'b0;
        imm_expect_d = 1'b0;
      end
      RUN: begin
        if (branch_taken) begin
          pc_d         = branch_target;
          instr_d      = INSTR_W'(NOP_WORD);
          imm_d        = 1'b0;
          imm_expect_d = 1'b0;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (take_int) begin
          instr_d       = INSTR_W'(NOP_WORD);
          imm_d         = 1'b0;
          ret_pc_d      = pc_q;
          int_ack_d     = 1'b1;
          int_pending_d = 1'b0;
        end else begin
          instr_d      = imem_data;
          imm_d        = imm_expect_q;
          imm_expect_d = !imm_expect_q && is_two_word;
          pc_d         = pc_inc;
          pc1_d        = pc_inc;
        end
      end
      INT_VEC: begin
        // a branch resolving behind the interrupt becomes the handler's return point
        ret_pc_d = branch_taken ? branch_target : ret_pc_q;
        if (!stall) begin
          pc_d    = PC_W'(imem_data);
          instr_d = INSTR_W'(NOP_WORD);
          imm_d   = 1'b0;
        end
      end
      default: pc_d = pc_q;
    endcase
  end
  assign if_id_instr = instr_q;
  assign if_id_imm   = imm_q;
  assign if_id_pc1   = pc1_q;
  assign int_ack     = int_ack_q;
  assign int_ret_pc  = ret_pc_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [15:0] imem_addr, imem_data, branch_target, if_id_instr, if_id_pc1, int_ret_pc;
  logic stall = 1'b0, branch_taken = 1'b0, int_req = 1'b0;
  logic if_id_imm, int_ack;
  logic [15:0] mem [0:65535];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr];
  fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .int_req       (int_req),
    .if_id_instr   (if_id_instr),
    .if_id_imm     (if_id_imm),
    .if_id_pc1     (if_id_pc1),
    .int_ack       (int_ack),
    .int_ret_pc    (int_ret_pc)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end
  initial begin
    branch_target = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0000] = 16'h0010;
    mem[16'h0001] = 16'h0080;
    mem[16'h0010] = 16'h1200;
    mem[16'h0011] = 16'hC200;
    mem[16'h0012] = 16'h00FF;
    mem[16'h0013] = 16'h2300;
    mem[16'h0014] = 16'h3400;
    mem[16'h0040] = 16'h4500;
    mem[16'h0041] = 16'hD100;
    mem[16'h0042] = 16'h0033;
    mem[16'h0043] = 16'h5600;
    mem[16'h0080] = 16'h7000;
    mem[16'h0081] = 16'h7100;
    mem[16'hFFFF] = 16'h8100;
    #1;
    chk("rst_instr", if_id_instr, 0);
    chk("rst_pc1", if_id_pc1, 0);
    chk("rst_imm", if_id_imm, 0);
    chk("rst_ack", int_ack, 0);
    chk("rst_retpc", int_ret_pc, 0);
    chk("rst_addr", imem_addr, 0);
    #1 reset = 1'b1;
    tick;
    chk("boot_instr", if_id_instr, 0);
    chk("boot_pc", imem_addr, 16'h0010);
    tick;
    chk("first_instr", if_id_instr, 16'h1200);
    chk("first_pc1", if_id_pc1, 16'h0011);
    chk("first_imm", if_id_imm, 0);
    tick;
    chk("ldm_instr", if_id_instr, 16'hC200);
    chk("ldm_imm", if_id_imm, 0);
    tick;
    chk("imm_instr", if_id_instr, 16'h00FF);
    chk("imm_flag", if_id_imm, 1);
    tick;
    chk("after_imm_instr", if_id_instr, 16'h2300);
    chk("after_imm_flag", if_id_imm, 0);
    chk("after_imm_pc1", if_id_pc1, 16'h0014);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall_instr", if_id_instr, 16'h2300);
      chk("stall_pc1", if_id_pc1, 16'h0014);
      chk("stall_addr", imem_addr, 16'h0014);
    end
    stall = 1'b0;
    tick;
    chk("resume_instr", if_id_instr, 16'h3400);
    chk("resume_pc1", if_id_pc1, 16'h0015);
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_target = 16'h0040;
    tick;
    chk("br_stall_instr", if_id_instr, 0);
    chk("br_stall_addr", imem_addr, 16'h0040);
    stall = 1'b0;
    branch_taken = 1'b0;
    tick;
    chk("br_target_instr", if_id_instr, 16'h4500);
    chk("br_target_pc1", if_id_pc1, 16'h0041);
    tick;
    chk("ldd_instr", if_id_instr, 16'hD100);
    int_req = 1'b1;
    tick;
    int_req = 1'b0;
    chk("int_imm_first", if_id_instr, 16'h0033);
    chk("int_imm_flag", if_id_imm, 1);
    chk("int_no_ack_yet", int_ack, 0);
    tick;
    chk("int_ack", int_ack, 1);
    chk("int_retpc", int_ret_pc, 16'h0043);
    chk("int_bubble1", if_id_instr, 0);
    chk("int_vec_addr", imem_addr, 16'h0001);
    tick;
    chk("int_ack_pulse", int_ack, 0);
    chk("int_bubble2", if_id_instr, 0);
    chk("handler_addr", imem_addr, 16'h0080);
    tick;
    chk("handler_instr", if_id_instr, 16'h7000);
    chk("handler_pc1", if_id_pc1, 16'h0081);
    branch_taken = 1'b1;
    branch_target = 16'hFFFF;
    tick;
    branch_taken = 1'b0;
    chk("wrap_addr", imem_addr, 16'hFFFF);
    tick;
    chk("wrap_instr", if_id_instr, 16'h8100);
    chk("wrap_pc1", if_id_pc1, 16'h0000);
    chk("wrap_pc", imem_addr, 16'h0000);
    tick;
    chk("post_wrap_pc1", if_id_pc1, 16'h0001);
    stall = 1'b1;
    int_req = 1'b1;
    tick;
    stall = 1'b0;
    int_req = 1'b0;
    chk("int_stall_hold", if_id_instr, 16'h0010);
    chk("int_stall_noack", int_ack, 0);
    tick;
    chk("int_after_stall_ack", int_ack, 1);
    chk("int_after_stall_ret", int_ret_pc, 16'h0001);
    reset = 1'b0;
    #1;
    chk("midrst_instr", if_id_instr, 0);
    chk("midrst_pc1", if_id_pc1, 0);
    chk("midrst_ack", int_ack, 0);
    chk("midrst_ret", int_ret_pc, 0);
    chk("midrst_addr", imem_addr, 0);
    tick;
    chk("midrst_hold_ack", int_ack, 0);
    reset = 1'b1;
    tick;
    chk("reboot_instr", if_id_instr, 0);
    chk("reboot_ack", int_ack, 0);
    chk("reboot_addr", imem_addr, 16'h0010);
    tick;
    chk("reboot_first", if_id_instr, 16'h1200);
    chk("reboot_noack", int_ack, 0);
    int_req = 1'b1;
    tick;
    int_req = 1'b0;
    chk("ivbr_opcode", if_id_instr, 16'hC200);
    tick;
    chk("ivbr_imm", if_id_imm, 1);
    chk("ivbr_noack", int_ack, 0);
    tick;
    chk("ivbr_ack", int_ack, 1);
    chk("ivbr_ret0", int_ret_pc, 16'h0013);
    branch_taken = 1'b1;
    branch_target = 16'h0123;
    tick;
    branch_taken = 1'b0;
    chk("ivbr_ret", int_ret_pc, 16'h0123);
    chk("ivbr_addr", imem_addr, 16'h0080);
    tick;
    chk("ivbr_handler", if_id_instr, 16'h7000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
